// File: rtl/interrupt_controller.sv
// ============================================================================
// interrupt_controller
//
// Purpose:
//   Vectors the eight timer interrupt sources of the joint TIFR/TIMSK pair
//   into the program counter. A masked flag that is pending while SREG.I is
//   set is taken at the next instruction boundary. The controller then spends
//   one VECTOR cycle emitting the PC load, the flag clear and the SREG.I
//   clear, and stays in ISR until RETI. There is no nesting: nothing is taken
//   while an ISR is running.
//
//   Fixed priority, bit 7 highest:
//     n = 7 OCF2  -> 0x008        n = 3 OCF1B -> 0x010
//     n = 6 TOV2  -> 0x00A        n = 2 TOV1  -> 0x012
//     n = 5 ICF1  -> 0x00C        n = 1 OCF0  -> 0x014
//     n = 4 OCF1A -> 0x00E        n = 0 TOV0  -> 0x016
//
// Configuration:
//   INTC_RETI_GUARD_EN - when defined, RETI passes through a GUARD state that
//   waits for one instr_boundary pulse. This guarantees that one main-program
//   instruction runs before the next interrupt. When undefined, RETI returns
//   straight to IDLE.
//
// Ports:
//   sysClock        in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   tifr_in[7:0]    in   timer flag vector
//   timsk_in[7:0]   in   timer interrupt mask, same bit map as tifr_in
//   sreg_i          in   SREG global interrupt enable
//   instr_boundary  in   pulse when an instruction completes
//   reti            in   pulse when RETI executes
//   program_counter in   current word-address PC
//   PC_overwrite    out  pulse: program memory loads PC_new
//   PC_new[13:0]    out  vector word address
//   return_pc[13:0] out  PC captured at vectoring, held until the next one
//   tifr_clear[7:0] out  one-hot pulse clearing the serviced flag
//   sreg_i_clear    out  pulse clearing SREG.I
//   isr_active      out  high while in ISR
// ============================================================================
module interrupt_controller (
    input  logic        sysClock,
    input  logic        rst_n,
    input  logic [7:0]  tifr_in,
    input  logic [7:0]  timsk_in,
    input  logic        sreg_i,
    input  logic        instr_boundary,
    input  logic        reti,
    input  logic [13:0] program_counter,
    output logic        PC_overwrite,
    output logic [13:0] PC_new,
    output logic [13:0] return_pc,
    output logic [7:0]  tifr_clear,
    output logic        sreg_i_clear,
    output logic        isr_active
);

`ifdef INTC_RETI_GUARD_EN
    typedef enum logic [2:0] {
        IDLE,
        WAIT_BOUNDARY,
        VECTOR,
        ISR,
        GUARD
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        WAIT_BOUNDARY,
        VECTOR,
        ISR
    } state_t;
`endif

    state_t      state;
    logic [7:0]  pending;
    logic        irq_ok;
    logic [2:0]  top_bit;
    logic [13:0] vector_addr;

    // The highest set bit wins. Later iterations override earlier ones.
    function automatic logic [2:0] highest_bit(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign pending     = tifr_in & timsk_in;
    assign irq_ok      = (|pending) & sreg_i;
    assign top_bit     = highest_bit(pending);
    // 0x008 + 2*(7-n). Doubling the index is a left shift by one.
    assign vector_addr = 14'h008 + {10'd0, 3'd7 - top_bit, 1'b0};

    // All outputs are registered. The pulses are loaded on the edge that
    // enters VECTOR, so they are high exactly while the FSM sits in VECTOR
    // and fall back to zero on the following edge.
    always_ff @(posedge sysClock or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            PC_overwrite <= 1'b0;
            PC_new       <= 14'd0;
            return_pc    <= 14'd0;
            tifr_clear   <= 8'd0;
            sreg_i_clear <= 1'b0;
            isr_active   <= 1'b0;
        end else begin
            PC_overwrite <= 1'b0;
            sreg_i_clear <= 1'b0;
            tifr_clear   <= 8'd0;
            case (state)
                IDLE: begin
                    if (irq_ok) state <= WAIT_BOUNDARY;
                end
                WAIT_BOUNDARY: begin
                    // The request can be withdrawn up to the boundary itself.
                    if (!irq_ok) begin
                        state <= IDLE;
                    end else if (instr_boundary) begin
                        state        <= VECTOR;
                        PC_overwrite <= 1'b1;
                        sreg_i_clear <= 1'b1;
                        tifr_clear   <= 8'h01 << top_bit;
                        PC_new       <= vector_addr;
                        return_pc    <= program_counter;
                    end
                end
                VECTOR: begin
                    state      <= ISR;
                    isr_active <= 1'b1;
                end
                ISR: begin
                    if (reti) begin
                        isr_active <= 1'b0;
`ifdef INTC_RETI_GUARD_EN
                        state      <= GUARD;
`else
                        state      <= IDLE;
`endif
                    end
                end
`ifdef INTC_RETI_GUARD_EN
                GUARD: begin
                    if (instr_boundary) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
